// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding and status widths shared by the reset sequencer.
package rst_seq_pkg;
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      HOLD      = 2'd3
   } state_t;
   localparam int LOSS_W = 8;
endpackage

// File: rtl/rst_lock_filter.sv
// rst_lock_filter: requires lock high on LOCK_FILT+1 consecutive enabled edges,
// then pulses lock_ok for one cycle; lock_drop flags lock currently low.
module rst_lock_filter #(
   parameter int LOCK_FILT = 15,
   parameter int CW        = 8
) (
   input  logic clk_12M,
   input  logic n_reset,
   input  logic en,
   input  logic lock,
   output logic lock_ok,
   output logic lock_drop
);
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   assign lock_ok   = en & lock & (lock_cnt_q == CW'(LOCK_FILT));
   assign lock_drop = ~lock;
   // The count restarts on any low sample, outside the waiting phase, and once passed.
   always_comb lock_cnt_d = (en & lock & ~lock_ok) ? lock_cnt_q + 1'b1 : '0;
   always_ff @(posedge clk_12M) begin
      if (!n_reset) lock_cnt_q <= '0;
      else          lock_cnt_q <= lock_cnt_d;
   end
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: PLL-lock filtered, staged release of active-low domain resets with warm-reset handshake.
// Defining RST_SEQ_STATUS_EN adds the state_o and loss_cnt status outputs.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int STAGES    = 4,
   parameter int STAGE_DLY = 255,
   parameter int LOCK_FILT = 15,
   parameter int CW        = 8
) (
   input  logic              clk_12M,
   input  logic              n_reset,
   input  logic              lock,
   input  logic              sw_rst_req,
   input  logic              lost_clr,
   output logic              sw_rst_ack,
   output logic [STAGES-1:0] n_rst_out,
   output logic              ready,
   output logic              lock_lost
`ifdef RST_SEQ_STATUS_EN
   ,
   output logic [1:0]        state_o,
   output logic [LOSS_W-1:0] loss_cnt
`endif
);
   localparam int SW = STAGES > 1 ? $clog2(STAGES) : 1;
   state_t            state_q, state_d;
   logic [CW-1:0]     dly_q, dly_d;
   logic [SW-1:0]     stage_q, stage_d;
   logic [STAGES-1:0] n_rst_out_q, n_rst_out_d;
   logic              ready_q, ready_d, ack_q, ack_d, lost_q, lost_d, req_q;
   logic              lock_ok, lock_drop, loss, req_rise, dly_done;

   rst_lock_filter #(.LOCK_FILT(LOCK_FILT), .CW(CW)) u_filt (
      .clk_12M   (clk_12M),
      .n_reset   (n_reset),
      .en        (state_q == WAIT_LOCK),
      .lock      (lock),
      .lock_ok   (lock_ok),
      .lock_drop (lock_drop)
   );

   assign req_rise = sw_rst_req & ~req_q;
   assign dly_done = dly_q == CW'(STAGE_DLY);
   assign loss     = lock_drop & (state_q != WAIT_LOCK);

   always_comb begin
      state_d     = state_q;
      dly_d       = dly_q;
      stage_d     = stage_q;
      n_rst_out_d = n_rst_out_q;
      ready_d     = ready_q;
      ack_d       = 1'b0;
      lost_d      = loss | (lost_q & ~lost_clr);
      // Lock loss overrides every state action, including a pending ack.
      if (loss) begin
         state_d     = WAIT_LOCK;
         dly_d       = '0;
         stage_d     = '0;
         n_rst_out_d = '0;
         ready_d     = 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK: if (lock_ok) begin
               state_d = RELEASE;
               dly_d   = '0;
               stage_d = '0;
            end
            RELEASE: if (!dly_done) dly_d = dly_q + 1'b1;
            else begin
               n_rst_out_d = n_rst_out_q | (STAGES'(1) << stage_q);
               dly_d       = '0;
               stage_d     = stage_q + 1'b1;
               if (stage_q == SW'(STAGES - 1)) begin
                  ready_d = 1'b1;
                  state_d = RUN;
               end
            end
            RUN: if (req_rise) begin
               state_d     = HOLD;
               n_rst_out_d = '0;
               ready_d     = 1'b0;
               dly_d       = '0;
            end
            HOLD: if (!dly_done) dly_d = dly_q + 1'b1;
            else begin
               ack_d   = 1'b1;
               state_d = RELEASE;
               stage_d = '0;
               dly_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_12M) begin
      if (!n_reset) begin
         state_q     <= WAIT_LOCK;
         dly_q       <= '0;
         stage_q     <= '0;
         n_rst_out_q <= '0;
         ready_q     <= 1'b0;
         ack_q       <= 1'b0;
         lost_q      <= 1'b0;
         req_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dly_q       <= dly_d;
         stage_q     <= stage_d;
         n_rst_out_q <= n_rst_out_d;
         ready_q     <= ready_d;
         ack_q       <= ack_d;
         lost_q      <= lost_d;
         req_q       <= sw_rst_req;
      end
   end

   assign n_rst_out  = n_rst_out_q;
   assign ready      = ready_q;
   assign sw_rst_ack = ack_q;
   assign lock_lost  = lost_q;

`ifdef RST_SEQ_STATUS_EN
   logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
   always_comb loss_cnt_d = (loss && loss_cnt_q != '1) ? loss_cnt_q + 1'b1 : loss_cnt_q;
   always_ff @(posedge clk_12M) begin
      if (!n_reset) loss_cnt_q <= '0;
      else          loss_cnt_q <= loss_cnt_d;
   end
   assign state_o  = state_q;
   assign loss_cnt = loss_cnt_q;
`endif
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed and random checks of rst_seq_ctrl against an elapsed-time reference model.
module tb_rst_seq_ctrl;
   localparam int ST = 3, SD = 3, LF = 2;
   logic clk_12M = 1'b0, n_reset = 1'b0, lock = 1'b0, sw_rst_req = 1'b0, lost_clr = 1'b0;
   logic sw_rst_ack, ready, lock_lost;
   logic [ST-1:0] n_rst_out;
   logic [ST+2:0] obs;
`ifdef RST_SEQ_STATUS_EN
   logic [1:0] state_o;
   logic [7:0] loss_cnt;
`endif
   int total = 0, bad = 0;
   int m_phase, m_run, m_t, m_n, m_losses, edge_n;
   bit m_ready, m_ack, m_lost, m_preq;

   always #5 clk_12M = ~clk_12M;

   rst_seq_ctrl #(.STAGES(ST), .STAGE_DLY(SD), .LOCK_FILT(LF), .CW(8)) dut (
      .clk_12M    (clk_12M),
      .n_reset    (n_reset),
      .lock       (lock),
      .sw_rst_req (sw_rst_req),
      .lost_clr   (lost_clr),
      .sw_rst_ack (sw_rst_ack),
      .n_rst_out  (n_rst_out),
      .ready      (ready),
      .lock_lost  (lock_lost)
`ifdef RST_SEQ_STATUS_EN
      ,
      .state_o    (state_o),
      .loss_cnt   (loss_cnt)
`endif
   );

   assign obs = {n_rst_out, ready, sw_rst_ack, lock_lost};

   // Model phases: 0 waiting for lock, 1 releasing, 2 running, 3 warm hold.
   // Released stage count is derived from time elapsed since the release began.
   function automatic logic [ST+2:0] exp_vec();
      return {ST'((1 << m_n) - 1), m_ready, m_ack, m_lost};
   endfunction

   task automatic model_edge();
      bit rise, lossev;
      if (!n_reset) begin
         edge_n = 0; m_phase = 0; m_run = 0; m_t = 0; m_n = 0; m_losses = 0;
         m_ready = 0; m_ack = 0; m_lost = 0; m_preq = 0;
         return;
      end
      edge_n++;
      m_ack  = 0;
      rise   = sw_rst_req && !m_preq;
      m_preq = sw_rst_req;
      lossev = !lock && m_phase != 0;
      m_lost = lossev ? 1'b1 : (lost_clr ? 1'b0 : m_lost);
      if (lossev) begin
         m_phase = 0; m_run = 0; m_n = 0; m_ready = 0;
         if (m_losses < 255) m_losses++;
      end else if (m_phase == 0) begin
         m_run = lock ? m_run + 1 : 0;
         if (m_run == LF + 1) begin m_phase = 1; m_t = 0; m_run = 0; end
      end else if (m_phase == 1) begin
         m_t++;
         m_n = m_t / (SD + 1);
         if (m_n == ST) begin m_phase = 2; m_ready = 1; end
      end else if (m_phase == 2) begin
         if (rise) begin m_phase = 3; m_t = 0; m_n = 0; m_ready = 0; end
      end else begin
         m_t++;
         if (m_t == SD + 1) begin m_ack = 1; m_phase = 1; m_t = 0; end
      end
   endtask

   task automatic tick(input bit r, input bit l, input bit q, input bit c);
      @(negedge clk_12M);
      n_reset = r; lock = l; sw_rst_req = q; lost_clr = c;
      @(posedge clk_12M);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 1, 0);
      tick(0, 1, 1, 1);
      total++; if (obs !== '0) begin bad++; $display("FAIL reset_vals got=%b want=%b", obs, {ST+3{1'b0}}); end
      tick(0, 0, 0, 0);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset_model got=%b want=%b", obs, exp_vec()); end
   endtask

   task automatic test_power_up();
      logic [ST-1:0] want;
      tick(0, 0, 0, 0);
      for (int i = 1; i <= 17; i++) begin
         tick(1, 1, 0, 0);
         want = i < 7 ? 3'b000 : i < 11 ? 3'b001 : i < 15 ? 3'b011 : 3'b111;
         total++; if (n_rst_out !== want || ready !== (i >= 15)) begin bad++; $display("FAIL power_up edge=%0d got=%b/%b want=%b/%b", i, n_rst_out, ready, want, i >= 15); end
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL power_up_model edge=%0d got=%b want=%b", i, obs, exp_vec()); end
      end
   endtask

   task automatic test_filter_restart();
      bit pat[6] = '{1, 1, 0, 1, 1, 1};
      tick(0, 0, 0, 0);
      for (int i = 1; i <= 11; i++) begin
         tick(1, i <= 6 ? pat[i-1] : 1'b1, 0, 0);
         total++; if (n_rst_out !== (i >= 10 ? 3'b001 : 3'b000) || lock_lost !== 1'b0) begin bad++; $display("FAIL filter edge=%0d got=%b lost=%b", i, n_rst_out, lock_lost); end
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL filter_model edge=%0d got=%b want=%b", i, obs, exp_vec()); end
      end
   endtask

   task automatic test_warm_reset();
      int idle;
      bit q;
      logic [ST-1:0] want;
      idle = $urandom_range(1, 5);
      tick(0, 0, 0, 0);
      for (int i = 0; i < 15 + idle; i++) tick(1, 1, 0, 0);
      for (int k = 0; k <= 16; k++) begin
         q = k == 0 ? 1'b1 : k == 1 ? 1'b0 : k == 2 ? 1'b1 : 1'($urandom_range(0, 1));
         tick(1, 1, q, 0);
         want = k < 8 ? 3'b000 : k < 12 ? 3'b001 : k < 16 ? 3'b011 : 3'b111;
         total++; if (sw_rst_ack !== (k == 4) || n_rst_out !== want || ready !== (k == 16)) begin bad++; $display("FAIL warm k=%0d got ack=%b out=%b rdy=%b want ack=%b out=%b", k, sw_rst_ack, n_rst_out, ready, k == 4, want); end
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL warm_model k=%0d got=%b want=%b", k, obs, exp_vec()); end
      end
   endtask

   task automatic test_lock_loss();
      tick(0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) tick(1, 1, 0, 0);
      tick(1, 0, 0, 1);
      total++; if (n_rst_out !== 3'b000 || lock_lost !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL loss_drop got out=%b lost=%b want out=000 lost=1", n_rst_out, lock_lost); end
      for (int i = 1; i <= 8; i++) begin
         tick(1, 1, 0, 0);
         total++; if (n_rst_out !== (i >= 7 ? 3'b001 : 3'b000) || lock_lost !== 1'b1) begin bad++; $display("FAIL loss_relock i=%0d got out=%b lost=%b", i, n_rst_out, lock_lost); end
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL loss_model i=%0d got=%b want=%b", i, obs, exp_vec()); end
      end
      tick(1, 1, 0, 1);
      total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL lost_clr got=%b want=0", lock_lost); end
`ifdef RST_SEQ_STATUS_EN
      total++; if (loss_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt got=%0d want=1", loss_cnt); end
`endif
   endtask

   task automatic test_reset_in_hold();
      int h;
      h = $urandom_range(0, 2);
      tick(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) tick(1, 1, 0, 0);
      tick(1, 1, 1, 0);
      for (int i = 0; i < h; i++) tick(1, 1, 1, 0);
      tick(0, 1, 1, 0);
      total++; if (obs !== '0) begin bad++; $display("FAIL hold_reset got=%b want=0", obs); end
      for (int i = 1; i <= 8; i++) begin
         tick(1, 1, 0, 0);
         total++; if (sw_rst_ack !== 1'b0 || n_rst_out !== (i >= 7 ? 3'b001 : 3'b000)) begin bad++; $display("FAIL hold_restart i=%0d got ack=%b out=%b", i, sw_rst_ack, n_rst_out); end
      end
   endtask

   task automatic test_random();
      bit r, l, q, c;
      q = 0;
      tick(0, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99) != 0;
         l = $urandom_range(0, 39) != 0;
         if ($urandom_range(0, 5) == 0) q = ~q;
         c = $urandom_range(0, 9) == 0;
         tick(r, l, q, c);
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL random i=%0d got=%b want=%b", i, obs, exp_vec()); end
         total++; if ((n_rst_out & (n_rst_out + 1'b1)) !== '0) begin bad++; $display("FAIL thermometer i=%0d got=%b", i, n_rst_out); end
`ifdef RST_SEQ_STATUS_EN
         total++; if (state_o !== 2'(m_phase) || loss_cnt !== 8'(m_losses)) begin bad++; $display("FAIL status i=%0d got st=%0d lc=%0d want st=%0d lc=%0d", i, state_o, loss_cnt, m_phase, m_losses); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_filter_restart();
      test_warm_reset();
      test_lock_loss();
      test_reset_in_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for the PLL clock tree. It watches the PLL lock flag on the free-running 12 MHz reference clock and filters it. After lock it releases a vector of active-low domain resets one stage at a time, with a programmable gap between stages. It also serves software-requested warm resets through a req/ack handshake. It sits between the PLL/divider block and every clocked subsystem (core, memory, peripherals).

Parameters:
STAGES, 4, number of reset domains released in order, bit 0 first
STAGE_DLY, 255, extra cycles of gap before each stage release (gap = STAGE_DLY+1)
LOCK_FILT, 15, lock must be seen high on LOCK_FILT+1 consecutive edges
CW, 8, width of the delay and filter counters; STAGE_DLY and LOCK_FILT must each be < 2^CW

Ports:
clk_12M  in  1  free-running reference clock, not PLL-derived
n_reset  in  1  synchronous, active-low reset
lock  in  1  PLL lock flag, already synchronised to clk_12M
sw_rst_req  in  1  warm-reset request; acted on at its rising edge
lost_clr  in  1  clears lock_lost
sw_rst_ack  out  1  one-cycle pulse when the warm-reset hold ends
n_rst_out  out  STAGES  active-low domain resets
ready  out  1  high when all stages are released
lock_lost  out  1  sticky flag: lock dropped after the filter first passed

Behaviour:
- Fixed interface decision: single clock clk_12M; n_reset is synchronous and active-low.
- All outputs are registered.
- Reset values: n_rst_out=0, ready=0, sw_rst_ack=0, lock_lost=0, state=WAIT_LOCK, lock_cnt=0, dly=0, stage=0, req_q=0.
- States: WAIT_LOCK, RELEASE, RUN, HOLD.
- WAIT_LOCK:
  - lock=0 → lock_cnt=0.
  - lock=1 and lock_cnt<LOCK_FILT → lock_cnt+1.
  - lock=1 and lock_cnt==LOCK_FILT → go to RELEASE with dly=0, stage=0.
- RELEASE, on each edge:
  - dly<STAGE_DLY → dly+1.
  - Otherwise → n_rst_out[stage]=1, dly=0, stage+1.
  - On releasing stage STAGES-1, the same edge sets ready=1 and goes to RUN.
- RUN: rising edge of sw_rst_req (req=1, req_q=0) → HOLD. On that edge n_rst_out=0, ready=0, dly=0.
- HOLD:
  - Counts STAGE_DLY+1 edges.
  - On the final edge, sw_rst_ack=1 for exactly one cycle and state goes to RELEASE with stage=0. The lock filter is not re-run.
- Lock loss: lock=0 in RELEASE, RUN or HOLD causes, on the same edge:
  - n_rst_out=0, ready=0, lock_lost=1;
  - state → WAIT_LOCK, counters cleared.
  - Lock loss has priority over a sw request and over the HOLD→RELEASE exit; no ack is issued in that case.
- sw_rst_req edges outside RUN are ignored and not queued. req_q updates every cycle.
- lost_clr clears lock_lost. If lost_clr and a new lock loss occur on the same edge, set wins.
- n_reset low mid-sequence gives immediate full reset values on that edge.
- Invariant: n_rst_out is always thermometer-coded, i.e. a released stage k implies all stages j<k are released.

Optional Feature:
- Macro: RST_SEQ_STATUS_EN.
- When defined, adds two outputs:
  - state_o (2 bits, encoding from the package).
  - loss_cnt (8 bits): counts lock-loss events, saturates at 255, cleared only by n_reset.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum with fixed encoding WAIT_LOCK=0, RELEASE=1, RUN=2, HOLD=3;
  - the loss_cnt width constant (8).
- One natural sub-module, rst_lock_filter:
  - implements the LOCK_FILT consecutive-high filter;
  - outputs a one-cycle lock_ok pulse and a drop indication;
  - is instantiated once.

Test Plan (STAGES=3, STAGE_DLY=3, LOCK_FILT=2; edge 1 = first edge with n_reset=1):
- Lock high from edge 1 → RELEASE entered at edge 3; n_rst_out=001 at edge 7, 011 at edge 11, 111 with ready=1 at edge 15.
- Lock pattern 1,1,0,1,1,1 from edge 1 → filter restarts; n_rst_out stays 000 until edge 10 (001); lock_lost stays 0.
- In RUN, sw_rst_req rises at edge E → n_rst_out=000, ready=0 at E; sw_rst_ack pulses at E+4 only; 001 at E+8; 111 at E+16. A second rise during HOLD gives no second ack.
- Lock drops at the edge where n_rst_out would become 011 → n_rst_out=000, lock_lost=1, WAIT_LOCK. Lock high again → 001 exactly 7 edges after lock returns high.
- lost_clr asserted on the same edge as a lock drop → lock_lost=1. lost_clr alone later → 0.
- n_reset pulled low for 1 cycle while in HOLD → all outputs at reset values, no ack. Sequence restarts from WAIT_LOCK.
